// File: rtl/pll_reset_sequencer.sv
// Bring-up sequencer for the video PLL: pulses the PLL reset, qualifies lock,
// then releases the pixel and draw domain resets in order; latches a fault after repeated timeouts.
module pll_reset_sequencer #(
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned STAGGER_CYCLES = 16,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       rst_pix,
    output logic       rst_draw,
    output logic       ready,
    output logic       fault,
    output logic [7:0] relock_count,
    output logic [2:0] state
);

    localparam int unsigned MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CD = (STABLE_CYCLES > STAGGER_CYCLES) ? STABLE_CYCLES : STAGGER_CYCLES;
    localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW     = (MAX_P > 2) ? $clog2(MAX_P) : 1;
    localparam int unsigned RW     = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_REL_PIX   = 3'd3,
        ST_REL_DRAW  = 3'd4,
        ST_RUN       = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_retries;
    logic [RW-1:0]   w_retries_next;
    logic [RW-1:0]   w_retries_plus;
    logic            w_relock_inc;
    logic            r_sync1;
    logic            r_lock_s;
    logic            r_pll_rst;
    logic            r_rst_pix;
    logic            r_rst_draw;
    logic            r_ready;
    logic            r_fault;
    logic [7:0]      r_relock;
    logic            w_pll_rst;
    logic            w_rst_pix;
    logic            w_rst_draw;
    logic            w_ready;
    logic            w_fault;

    assign w_retries_plus = r_retries + RW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= pll_locked;
            r_lock_s <= r_sync1;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_retries_next = r_retries;
        w_relock_inc   = 1'b0;
        case (r_state)
            ST_PLL_RST: begin
                if (r_cnt == CW'(RST_CYCLES - 1)) w_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (r_lock_s) begin
                    w_next = ST_SETTLE;
                end else if (r_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    w_retries_next = w_retries_plus;
                    w_next = (w_retries_plus == RW'(MAX_RETRIES)) ? ST_FAULT : ST_PLL_RST;
                end
            end
            ST_SETTLE: begin
                if (!r_lock_s) w_next = ST_WAIT_LOCK;
                else if (r_cnt == CW'(STABLE_CYCLES - 1)) w_next = ST_REL_PIX;
            end
            ST_REL_PIX, ST_REL_DRAW, ST_RUN: begin
                // Lock loss outranks any stagger expiry in the same cycle.
                if (!r_lock_s) begin
                    w_next         = ST_PLL_RST;
                    w_relock_inc   = 1'b1;
                    w_retries_next = '0;
                end else if (r_state == ST_REL_PIX && r_cnt == CW'(STAGGER_CYCLES - 1)) begin
                    w_next = ST_REL_DRAW;
                end else if (r_state == ST_REL_DRAW && r_cnt == CW'(STAGGER_CYCLES - 1)) begin
                    w_next         = ST_RUN;
                    w_retries_next = '0;
                end
            end
            ST_FAULT: w_next = ST_FAULT;
            default:  w_next = ST_PLL_RST;
        endcase
    end

    // Outputs are decoded from the next state and registered so they move with the state edge.
    always_comb begin
        w_pll_rst  = (w_next == ST_PLL_RST) || (w_next == ST_FAULT);
        w_rst_pix  = !((w_next == ST_REL_PIX) || (w_next == ST_REL_DRAW) || (w_next == ST_RUN));
        w_rst_draw = !((w_next == ST_REL_DRAW) || (w_next == ST_RUN));
        w_ready    = (w_next == ST_RUN);
        w_fault    = (w_next == ST_FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_PLL_RST;
            r_cnt      <= '0;
            r_retries  <= '0;
            r_relock   <= 8'd0;
            r_pll_rst  <= 1'b1;
            r_rst_pix  <= 1'b1;
            r_rst_draw <= 1'b1;
            r_ready    <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
            r_retries  <= w_retries_next;
            if (w_relock_inc && r_relock != 8'hFF) r_relock <= r_relock + 8'd1;
            r_pll_rst  <= w_pll_rst;
            r_rst_pix  <= w_rst_pix;
            r_rst_draw <= w_rst_draw;
            r_ready    <= w_ready;
            r_fault    <= w_fault;
        end
    end

    assign pll_rst      = r_pll_rst;
    assign rst_pix      = r_rst_pix;
    assign rst_draw     = r_rst_draw;
    assign ready        = r_ready;
    assign fault        = r_fault;
    assign relock_count = r_relock;
    assign state        = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed and randomized bench for pll_reset_sequencer against a cycle-level reference
// model of the bring-up rules, plus explicit edge-count checks of the timing contract.
module tb_pll_reset_sequencer;

    localparam int RST_C   = 4;
    localparam int TMO_C   = 32;
    localparam int STAB_C  = 8;
    localparam int STAG_C  = 2;
    localparam int MAX_R   = 2;

    localparam int SEL_STATE  = 0;
    localparam int SEL_PLLRST = 1;
    localparam int SEL_PIX    = 2;
    localparam int SEL_DRAW   = 3;
    localparam int SEL_READY  = 4;
    localparam int SEL_FAULT  = 5;
    localparam int SEL_RELOCK = 6;

    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       rst_pix;
    logic       rst_draw;
    logic       ready;
    logic       fault;
    logic [7:0] relock_count;
    logic [2:0] state;

    int checks;
    int errors;

    // Reference model: phase number, time spent in phase, retry and relock tallies,
    // and the two-sample delay of the lock synchronizer.
    int m_ph;
    int m_t;
    int m_ret;
    int m_relock;
    int m_s1;
    int m_s2;

    pll_reset_sequencer #(
        .RST_CYCLES(RST_C), .LOCK_TIMEOUT(TMO_C), .STABLE_CYCLES(STAB_C),
        .STAGGER_CYCLES(STAG_C), .MAX_RETRIES(MAX_R)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst),
        .rst_pix(rst_pix), .rst_draw(rst_draw), .ready(ready), .fault(fault),
        .relock_count(relock_count), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_t = 0; m_ret = 0; m_relock = 0; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic enter(input int ph);
        m_ph = ph;
        m_t  = 0;
    endtask

    task automatic model_step();
        int lk;
        lk   = m_s2;
        m_s2 = m_s1;
        m_s1 = int'(pll_locked);
        if (m_ph >= 3 && m_ph <= 5 && lk == 0) begin
            m_relock = (m_relock < 255) ? m_relock + 1 : 255;
            m_ret    = 0;
            enter(0);
        end else if (m_ph == 0 && m_t == RST_C - 1) begin
            enter(1);
        end else if (m_ph == 1 && lk == 1) begin
            enter(2);
        end else if (m_ph == 1 && m_t == TMO_C - 1) begin
            m_ret++;
            enter((m_ret == MAX_R) ? 6 : 0);
        end else if (m_ph == 2 && lk == 0) begin
            enter(1);
        end else if (m_ph == 2 && m_t == STAB_C - 1) begin
            enter(3);
        end else if (m_ph == 3 && m_t == STAG_C - 1) begin
            enter(4);
        end else if (m_ph == 4 && m_t == STAG_C - 1) begin
            m_ret = 0;
            enter(5);
        end else begin
            m_t++;
        end
    endtask

    task automatic compare_all();
        check("state", 32'(state), 32'(m_ph));
        check("pll_rst", 32'(pll_rst), 32'(m_ph == 0 || m_ph == 6));
        check("rst_pix", 32'(rst_pix), 32'(!(m_ph >= 3 && m_ph <= 5)));
        check("rst_draw", 32'(rst_draw), 32'(!(m_ph == 4 || m_ph == 5)));
        check("ready", 32'(ready), 32'(m_ph == 5));
        check("fault", 32'(fault), 32'(m_ph == 6));
        check("relock_count", 32'(relock_count), 32'(m_relock));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            SEL_STATE:  return 32'(state);
            SEL_PLLRST: return 32'(pll_rst);
            SEL_PIX:    return 32'(rst_pix);
            SEL_DRAW:   return 32'(rst_draw);
            SEL_READY:  return 32'(ready);
            SEL_FAULT:  return 32'(fault);
            default:    return 32'(relock_count);
        endcase
    endfunction

    // Ticks until the selected output equals val; an expired budget is a failed comparison.
    task automatic wait_cond(input string tag, input int sel, input int val, input int budget,
                             output int n);
        n = 0;
        while (n < budget && obs(sel) !== 32'(val)) begin
            tick();
            n++;
        end
        check(tag, obs(sel), 32'(val));
    endtask

    task automatic do_reset(input logic lock_val);
        rst = 1'b1;
        pll_locked = lock_val;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        pll_locked = 1'b0;
        model_reset();
        #1;
        compare_all();
        tick();
        tick();

        // Nominal bring-up with lock arriving 10 cycles after reset release.
        rst = 1'b0;
        wait_cond("pll_rst_fall", SEL_PLLRST, 0, 20, n);
        check("pll_rst_len", n, RST_C);
        repeat (10 - RST_C) tick();
        pll_locked = 1'b1;
        wait_cond("enter_settle", SEL_STATE, 2, 50, n);
        wait_cond("rst_pix_fall", SEL_PIX, 0, 30, n);
        check("settle_len", n, STAB_C);
        wait_cond("rst_draw_fall", SEL_DRAW, 0, 30, n);
        check("stagger_draw", n, STAG_C);
        wait_cond("ready_rise", SEL_READY, 1, 30, n);
        check("stagger_ready", n, STAG_C);
        check("nominal_relock", 32'(relock_count), 0);

        // One-cycle lock glitch during SETTLE restarts the qualification.
        do_reset(1'b1);
        wait_cond("glitch_settle", SEL_STATE, 2, 50, n);
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_cond("glitch_back_wait", SEL_STATE, 1, 10, n);
        check("glitch_rst_pix", 32'(rst_pix), 1);
        wait_cond("glitch_resettle", SEL_STATE, 2, 10, n);
        wait_cond("glitch_pix_fall", SEL_PIX, 0, 30, n);
        check("glitch_settle_len", n, STAB_C);

        // Lock never arrives: two timeouts end in FAULT.
        do_reset(1'b0);
        wait_cond("tmo_wait1", SEL_STATE, 1, 20, n);
        check("tmo_rst1_len", n, RST_C);
        wait_cond("tmo_retry", SEL_STATE, 0, 60, n);
        check("tmo_wait1_len", n, TMO_C);
        wait_cond("tmo_wait2", SEL_STATE, 1, 20, n);
        check("tmo_rst2_len", n, RST_C);
        wait_cond("tmo_fault", SEL_STATE, 6, 60, n);
        check("tmo_wait2_len", n, TMO_C);
        repeat (40) tick();
        pll_locked = 1'b1;
        repeat (20) tick();
        check("fault_held_state", 32'(state), 6);
        check("fault_held_flag", 32'(fault), 1);
        check("fault_held_pll_rst", 32'(pll_rst), 1);

        // Lock loss in RUN, then 256 further losses to saturate the counter.
        do_reset(1'b1);
        wait_cond("loss_ready", SEL_READY, 1, 60, n);
        pll_locked = 1'b0;
        tick();
        tick();
        check("loss_ready_hold", 32'(ready), 1);
        tick();
        check("loss_ready", 32'(ready), 0);
        check("loss_rst_pix", 32'(rst_pix), 1);
        check("loss_rst_draw", 32'(rst_draw), 1);
        check("loss_pll_rst", 32'(pll_rst), 1);
        check("loss_relock", 32'(relock_count), 1);
        pll_locked = 1'b1;
        wait_cond("relock_ready", SEL_READY, 1, 60, n);
        for (int i = 0; i < 256; i++) begin
            pll_locked = 1'b0;
            repeat (3) tick();
            pll_locked = 1'b1;
            wait_cond("sat_ready", SEL_READY, 1, 60, n);
        end
        check("relock_saturated", 32'(relock_count), 255);

        // One timeout, then lock; a later single timeout must retry, and a second one faults.
        do_reset(1'b0);
        wait_cond("retry_wait", SEL_STATE, 1, 20, n);
        wait_cond("retry_timeout", SEL_STATE, 0, 60, n);
        wait_cond("retry_wait2", SEL_STATE, 1, 20, n);
        pll_locked = 1'b1;
        wait_cond("retry_ready", SEL_READY, 1, 60, n);
        pll_locked = 1'b0;
        wait_cond("retry_loss", SEL_STATE, 0, 10, n);
        wait_cond("retry_wait3", SEL_STATE, 1, 20, n);
        wait_cond("retry_again", SEL_STATE, 0, 60, n);
        check("retry_again_len", n, TMO_C);
        check("retry_no_fault", 32'(fault), 0);
        wait_cond("retry_wait4", SEL_STATE, 1, 20, n);
        wait_cond("retry_fault", SEL_STATE, 6, 60, n);
        check("retry_fault_len", n, TMO_C);

        // Asynchronous reset between edges while in REL_DRAW.
        do_reset(1'b1);
        wait_cond("async_ready", SEL_READY, 1, 60, n);
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        wait_cond("async_rel_draw", SEL_STATE, 4, 60, n);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("async_relock", 32'(relock_count), 0);
        tick();
        rst = 1'b0;

        // Random lock activity with occasional resets.
        for (int seg = 0; seg < 60; seg++) begin
            pll_locked = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 45)) tick();
            if ($urandom_range(0, 9) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
